de_decoder: RTL

Horizontal display-enable decoder: the receiving end of the GSTMCU DE/HSYNC/VSYNC timing outputs. It measures each line's length, DE start offset and DE width in m2clock cycles, classifies the video mode (PAL / NTSC / mono / unknown) and flags overscan. It sits beside the shifter/scaler path and feeds the OSD/scaler configuration logic and debug registers.

---
 rtl/gstmcu_pkg.sv | 32 +++
 rtl/de_mode_classify.sv | 49 ++++
 rtl/de_decoder.sv | 135 +++++++++++++
 3 files changed

// File: rtl/gstmcu_pkg.sv
// rtl/gstmcu_pkg.sv - GSTMCU video timing constants, mode encoding and decode helpers
package gstmcu_pkg;

  typedef enum logic {
    SYNC_WAIT = 1'b0,
    MEASURE   = 1'b1
  } de_state_t;

  localparam logic [1:0] MODE_UNKNOWN = 2'd0;
  localparam logic [1:0] MODE_PAL     = 2'd1;
  localparam logic [1:0] MODE_NTSC    = 2'd2;
  localparam logic [1:0] MODE_MONO    = 2'd3;

  localparam int unsigned LINE_LEN_PAL  = 128;
  localparam int unsigned LINE_LEN_NTSC = 127;
  localparam int unsigned LINE_LEN_MONO = 56;

  localparam int unsigned DE_NOM_COLOR = 80;
  localparam int unsigned DE_NOM_MONO  = 40;

  function automatic logic [1:0] classify_len(input int unsigned len);
    if (len == LINE_LEN_PAL) return MODE_PAL;
    if (len == LINE_LEN_NTSC) return MODE_NTSC;
    if (len == LINE_LEN_MONO) return MODE_MONO;
    return MODE_UNKNOWN;
  endfunction

  function automatic int unsigned nominal_de(input logic [1:0] mode);
    return (mode == MODE_MONO) ? DE_NOM_MONO : DE_NOM_COLOR;
  endfunction

endpackage

// File: rtl/de_mode_classify.sv
// rtl/de_mode_classify.sv - line length stability filter plus mode and overscan decode
module de_mode_classify
  import gstmcu_pkg::*;
#(
  parameter int CNT_W        = 8,
  parameter int STABLE_LINES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             update,
  input  logic [CNT_W-1:0] line_len,
  input  logic [CNT_W-1:0] de_len,
  output logic [1:0]       mode,
  output logic             overscan
);
  localparam int RUN_W = $clog2(STABLE_LINES + 1);
  localparam logic [CNT_W-1:0] LEN_SAT = '1;
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_LINES);

  logic [CNT_W-1:0] prev_len;
  logic [RUN_W-1:0] run, run_next;
  logic [1:0]       line_mode, mode_next;
  logic             overscan_next;

  // Overscan is judged against the mode being committed this update, not the old one.
  always_comb begin
    line_mode = (line_len == LEN_SAT) ? MODE_UNKNOWN : classify_len(32'(line_len));
    if (line_len != prev_len) run_next = RUN_W'(1);
    else if (run == RUN_MAX) run_next = run;
    else run_next = run + 1'b1;
    mode_next = (run_next == RUN_MAX) ? line_mode : mode;
    overscan_next = (mode_next != MODE_UNKNOWN) && (32'(de_len) > nominal_de(mode_next));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_len <= '0;
      run      <= '0;
      mode     <= MODE_UNKNOWN;
      overscan <= 1'b0;
    end else if (update) begin
      prev_len <= line_len;
      run      <= run_next;
      mode     <= mode_next;
      overscan <= overscan_next;
    end
  end

endmodule

// File: rtl/de_decoder.sv
// rtl/de_decoder.sv - DE/HSYNC line measurement and mode decoder; DE_DEC_FRAME_EN adds per-frame active line count
module de_decoder
  import gstmcu_pkg::*;
#(
  parameter int CNT_W        = 8,
  parameter int STABLE_LINES = 2
) (
  input  logic             m2clock,
  input  logic             por,
  input  logic             de,
  input  logic             hsync,
  input  logic             vsync,
  output logic [CNT_W-1:0] line_len,
  output logic [CNT_W-1:0] de_start,
  output logic [CNT_W-1:0] de_len,
  output logic             meas_valid,
  output logic [1:0]       mode,
  output logic             overscan,
  output logic [9:0]       act_lines,
  output logic             frame_valid
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  de_state_t        state, state_next;
  logic             hsync_d, de_d, hs_rise, de_rise, publish, pub_pend, seen_de;
  logic [CNT_W-1:0] cnt, start_r, len_r;

  assign hs_rise = hsync & ~hsync_d;
  assign de_rise = de & ~de_d;
  assign publish = (state == MEASURE) && hs_rise;

  always_comb begin
    state_next = state;
    if (state == SYNC_WAIT && hs_rise) state_next = MEASURE;
  end

  always_ff @(posedge m2clock or posedge por) begin
    if (por) state <= SYNC_WAIT;
    else state <= state_next;
  end

  // cnt reads (cycles since hsync rise - 1), so offsets are published as cnt+1.
  always_ff @(posedge m2clock or posedge por) begin
    if (por) begin
      hsync_d    <= 1'b0;
      de_d       <= 1'b0;
      pub_pend   <= 1'b0;
      meas_valid <= 1'b0;
      cnt        <= '0;
      start_r    <= '0;
      len_r      <= '0;
      seen_de    <= 1'b0;
      line_len   <= '0;
      de_start   <= '0;
      de_len     <= '0;
    end else begin
      hsync_d    <= hsync;
      de_d       <= de;
      pub_pend   <= publish;
      meas_valid <= pub_pend;
      if (hs_rise) begin
        cnt     <= '0;
        start_r <= '0;
        len_r   <= de ? CNT_W'(1) : '0;
        seen_de <= de_rise;
        if (publish) begin
          line_len <= sat_inc(cnt);
          de_start <= seen_de ? start_r : '0;
          de_len   <= len_r;
        end
      end else if (state == MEASURE) begin
        cnt <= sat_inc(cnt);
        if (de_rise && !seen_de) begin
          start_r <= sat_inc(cnt);
          seen_de <= 1'b1;
        end
        if (de) len_r <= sat_inc(len_r);
      end
    end
  end

  de_mode_classify #(
    .CNT_W        (CNT_W),
    .STABLE_LINES (STABLE_LINES)
  ) u_classify (
    .clk      (m2clock),
    .rst      (por),
    .update   (pub_pend),
    .line_len (line_len),
    .de_len   (de_len),
    .mode     (mode),
    .overscan (overscan)
  );

`ifdef DE_DEC_FRAME_EN
  localparam logic [9:0] LINES_MAX = '1;

  logic       vsync_d, vs_rise, frame_armed, line_active;
  logic [9:0] frame_cnt;

  assign vs_rise     = vsync & ~vsync_d;
  assign line_active = publish & seen_de;

  // The first vsync only arms the counter; its partial frame is never reported.
  always_ff @(posedge m2clock or posedge por) begin
    if (por) begin
      vsync_d     <= 1'b0;
      frame_armed <= 1'b0;
      frame_cnt   <= '0;
      act_lines   <= '0;
      frame_valid <= 1'b0;
    end else begin
      vsync_d     <= vsync;
      frame_valid <= vs_rise & frame_armed;
      if (vs_rise) begin
        if (frame_armed) act_lines <= frame_cnt;
        frame_armed <= 1'b1;
        frame_cnt   <= {9'd0, line_active};
      end else if (line_active && frame_cnt != LINES_MAX) begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end
`else
  logic unused_vsync;
  assign unused_vsync = vsync;
  assign act_lines    = '0;
  assign frame_valid  = 1'b0;
`endif

endmodule
